// File: rtl/mem_copy_initiator_pkg.sv
// Shared types and constants for the memory-copy initiator.
// Holds the FSM encoding, default window base/depth and word size.
package mem_copy_initiator_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_CAPTURE = 3'd2,
        S_WRITE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h10001000;
    localparam int          DEF_DEPTH     = 16;
    localparam int          WORD_BYTES    = 4;

endpackage

// File: rtl/mem_copy_initiator_if.sv
// Word-wide memory bus between the copy initiator and data memory.
// master drives address/data/strobes, slave returns read data.
interface mem_copy_initiator_if;

    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        mem_read;
    logic        mem_write;

    modport master (
        output address,
        output write_data,
        output mem_read,
        output mem_write,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  mem_read,
        input  mem_write,
        output read_data
    );

endinterface

// File: rtl/mem_copy_initiator.sv
// Word-by-word memory copy engine: READ, CAPTURE, WRITE per word.
// Optional running checksum of written words under COPY_CHECKSUM_EN.
module mem_copy_initiator
    import mem_copy_initiator_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          DEPTH     = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [31:0]  src_addr,
    input  logic [31:0]  dst_addr,
    input  logic [4:0]   word_count,
    output logic         busy,
    output logic         done,
    output logic         error,
`ifdef COPY_CHECKSUM_EN
    output logic [31:0]  checksum,
`endif
    mem_copy_initiator_if.master bus
);

    state_t      state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [4:0]  cnt;
    logic [31:0] data;

    // True when [a, a + 4n) is not inside the memory window.
    function automatic logic range_bad(logic [31:0] a, logic [4:0] n);
        logic [32:0] diff;
        logic [32:0] end_w;
        diff  = {1'b0, a} - {1'b0, BASE_ADDR};
        end_w = {3'b0, diff[31:2]} + {28'b0, n};
        return diff[32] || (end_w > 33'(DEPTH));
    endfunction

    logic param_err;

    assign param_err = (|src_addr[1:0]) || (|dst_addr[1:0])
                    || (word_count > 5'd16)
                    || range_bad(src_addr, word_count)
                    || range_bad(dst_addr, word_count);

    // Copy sequencer; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            src            <= '0;
            dst            <= '0;
            cnt            <= '0;
            data           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            bus.address    <= '0;
            bus.write_data <= '0;
            bus.mem_read   <= 1'b0;
            bus.mem_write  <= 1'b0;
`ifdef COPY_CHECKSUM_EN
            checksum       <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        src   <= src_addr;
                        dst   <= dst_addr;
                        cnt   <= word_count;
                        error <= param_err;
`ifdef COPY_CHECKSUM_EN
                        checksum <= '0;
`endif
                        if (param_err || word_count == 5'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= S_READ;
                            busy         <= 1'b1;
                            bus.mem_read <= 1'b1;
                            bus.address  <= src_addr;
                        end
                    end
                end
                S_READ: begin
                    state        <= S_CAPTURE;
                    bus.mem_read <= 1'b0;
                end
                S_CAPTURE: begin
                    state          <= S_WRITE;
                    data           <= bus.read_data;
                    bus.write_data <= bus.read_data;
                    bus.address    <= dst;
                    bus.mem_write  <= 1'b1;
                end
                S_WRITE: begin
                    bus.mem_write <= 1'b0;
                    src           <= src + 32'(WORD_BYTES);
                    dst           <= dst + 32'(WORD_BYTES);
                    cnt           <= cnt - 5'd1;
`ifdef COPY_CHECKSUM_EN
                    checksum      <= checksum + data;
`endif
                    if (cnt == 5'd1) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state        <= S_READ;
                        bus.mem_read <= 1'b1;
                        bus.address  <= src + 32'(WORD_BYTES);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
